// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, parity helper and
// time-to-cycle conversions used by both the host transmitter and the mouse receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_WAIT1,
    ST_SHIFT,
    ST_ACK,
    ST_IDLE_WAIT,
    ST_ERR
  } tx_state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    longint unsigned p;
    p = 64'(clk_hz) * 64'(us);
    return 32'(p / 64'd1_000_000);
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    longint unsigned p;
    p = 64'(clk_hz) * 64'(ms);
    return 32'(p / 64'd1_000);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pads plus a registered
// falling-edge pulse on the synchronised clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_clk,
  input  logic pad_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle bus level is high, so flops reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      clk_prev <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_ff   <= {clk_ff[0], pad_clk};
      data_ff  <= {data_ff[0], pad_data};
      clk_prev <= clk_ff[1];
      clk_fall <= clk_prev & ~clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity,
// stop release and ACK check, with first-clock and whole-frame timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 75_000_000,
  parameter int unsigned INHIBIT_US   = 120,
  parameter int unsigned FIRST_CLK_MS = 15,
  parameter int unsigned FRAME_MS     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_CYC   = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned FIRST_CYC = ms_to_cycles(CLK_HZ, FIRST_CLK_MS);
  localparam int unsigned FRAME_CYC = ms_to_cycles(CLK_HZ, FRAME_MS);
  localparam int unsigned MAX_A     = (INH_CYC > FIRST_CYC) ? INH_CYC : FIRST_CYC;
  localparam int unsigned MAX_CYC   = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
  localparam int unsigned CW        = $clog2(MAX_CYC + 1);

  logic clk_s;
  logic data_s;
  logic fall;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .pad_clk  (ps2_clk_i),
    .pad_data (ps2_data_i),
    .clk_sync (clk_s),
    .data_sync(data_s),
    .clk_fall (fall)
  );

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_q, bit_d;
  logic [8:0]     shreg_q, shreg_d;
  logic           drive_q, drive_d;
  logic           accept;
  logic           timeout;

  assign tx_ready = (state_q == ST_IDLE);
  assign accept   = tx_valid & tx_ready;
  assign busy     = ~tx_ready | tx_valid;
  assign timeout  = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      drive_q <= drive_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    drive_d     = drive_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_INHIBIT;
          cnt_d   = CW'(INH_CYC);
          shreg_d = {odd_parity(tx_data), tx_data};
          bit_d   = '0;
          drive_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timeout) state_d = ST_START;
        else         cnt_d   = cnt_q - CW'(1);
      end
      // Start bit goes out one cycle before the clock is released.
      ST_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_d     = ST_WAIT1;
        cnt_d       = CW'(FIRST_CYC);
      end
      ST_WAIT1: begin
        ps2_data_oe = 1'b1;
        if (fall) begin
          state_d = ST_SHIFT;
          drive_d = ~shreg_q[0];
          shreg_d = {1'b0, shreg_q[8:1]};
          bit_d   = 4'd1;
          cnt_d   = CW'(FRAME_CYC);
        end else if (timeout) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SHIFT: begin
        ps2_data_oe = drive_q;
        if (timeout) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (fall) begin
            if (bit_q == 4'd9) begin
              state_d = ST_ACK;
            end else begin
              drive_d = ~shreg_q[0];
              shreg_d = {1'b0, shreg_q[8:1]};
              bit_d   = bit_q + 4'd1;
            end
          end
        end
      end
      ST_ACK: begin
        if (timeout) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (fall) state_d = data_s ? ST_ERR : ST_IDLE_WAIT;
        end
      end
      ST_IDLE_WAIT: begin
        if (timeout) begin
          state_d = ST_ERR;
        end else if (clk_s && data_s) begin
          state_d = ST_IDLE;
          tx_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ERR: begin
        tx_err  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames and records
// bits; expectations come from plain byte/parity arithmetic and timeout rules.
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned INH    = CLK_HZ / 1_000_000 * 120;
  localparam int unsigned FIRST  = CLK_HZ / 1_000 * 15;
  localparam int LIMIT           = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_i  (clk_line),
    .ps2_data_i (data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  typedef struct {
    logic [7:0] data;
    logic       ok;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Device model: 0 = normal ACK, 1 = no ACK, 2 = never clocks
  int         dev_mode = 0;
  bit         dev_busy = 1'b0;
  int         dev_edges = 0;
  logic [7:0] dev_byte = '0;
  logic       dev_par = 1'b0;
  logic       dev_stop = 1'b0;

  initial begin
    int half;
    forever begin
      @(posedge clk);
      if (dev_mode != 2 && rst_n && !ps2_clk_oe && ps2_data_oe && clk_line && !dev_busy) begin
        dev_busy  = 1'b1;
        dev_edges = 0;
        half      = int'($urandom_range(20, 40));
        repeat ($urandom_range(5, 50)) @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
          #1 dev_clk = 1'b0;
          dev_edges = k;
          repeat (half) @(posedge clk);
          #1 dev_clk = 1'b1;
          if (k <= 8)       dev_byte[k-1] = data_line;
          else if (k == 9)  dev_par = data_line;
          else if (k == 10) begin
            dev_stop = data_line;
            if (dev_mode == 0) dev_data = 1'b0;
          end else dev_data = 1'b1;
          repeat (half) @(posedge clk);
        end
        dev_busy = 1'b0;
      end
    end
  end

  // Monitor
  longint cyc = 0, inh_start = 0, rel_cyc = 0;
  logic   clk_oe_prev = 1'b0, data_oe_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (ps2_clk_oe && !clk_oe_prev) inh_start = cyc;
      if (!ps2_clk_oe && clk_oe_prev) rel_cyc = cyc;
      if (ps2_data_oe && !data_oe_prev && ps2_clk_oe)
        check_range("inhibit_hold", cyc - inh_start, INH, INH + 2);
      if (tx_done || tx_err) begin
        check("done_err_exclusive", tx_done & tx_err, 0);
        check("outcome_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("outcome_done", tx_done, e.ok);
          if (e.to) begin
            check_range("first_clk_timeout", cyc - rel_cyc, FIRST, FIRST + 2);
          end else begin
            check("frame_byte", dev_byte, e.data);
            check("frame_parity", dev_par, ($countones(e.data) % 2 == 0));
            check("frame_stop", dev_stop, 1);
          end
        end
        if (tx_err) begin
          check("err_clk_released", ps2_clk_oe, 0);
          check("err_data_released", ps2_data_oe, 0);
        end
      end
    end
    clk_oe_prev  = ps2_clk_oe;
    data_oe_prev = ps2_data_oe;
  end

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      if (tx_ready && !dev_busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_quiet: got timeout expected idle"); end
  endtask

  task automatic wait_edges(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      if (dev_busy && dev_edges >= n) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_edges: got timeout expected edge %0d", n); end
  endtask

  task automatic send(input logic [7:0] b, input bit push, input logic ok, input logic to);
    @(posedge clk);
    #1;
    tx_data  = b;
    tx_valid = 1'b1;
    #1;
    check("ready_before_accept", tx_ready, 1);
    check("busy_on_accept", busy, 1);
    if (push) exp_q.push_back('{b, ok, to});
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check("ready_low_after_accept", tx_ready, 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    send(8'hF4, 1, 1, 0); wait_quiet();
    send(8'hFF, 1, 1, 0); wait_quiet();
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 1, 1, 0); wait_quiet();
    end

    dev_mode = 1;
    send(8'($urandom), 1, 0, 0); wait_quiet();

    dev_mode = 2;
    send(8'hFF, 1, 0, 1); wait_quiet();
    check("ready_after_timeout", tx_ready, 1);
    dev_mode = 0;

    send(8'hF4, 0, 1, 0);
    wait_edges(5);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    check("midrst_ready", tx_ready, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", tx_ready, 1);
    wait_quiet();
    send(8'hF4, 1, 1, 0); wait_quiet();

    send(8'h3C, 1, 1, 0);
    wait_edges(3);
    @(posedge clk);
    #1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("ready_low_while_busy", tx_ready, 0);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_quiet();
    repeat (20) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
